// File: rtl/loadable_dff_pkg.sv
// Shared defaults for the loadable flip-flop slice and the registers built from it.
package loadable_dff_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 1;
    localparam logic        DEFAULT_RST_VAL = 1'b0;

endpackage

// File: rtl/loadable_dff_cell.sv
// One-bit loadable flop with asynchronous active-low clear (module dff_cell).
module dff_cell
    import loadable_dff_pkg::*;
#(
    parameter logic RST_VAL = DEFAULT_RST_VAL
) (
    input  logic d,
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic q
);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/loadable_dff.sv
// WIDTH-bit loadable register built from dff_cell slices, async active-low clear.
// Optional `valid` output is enabled by defining LOADABLE_DFF_VALID_EN.
module loadable_dff
    import loadable_dff_pkg::*;
#(
    parameter int unsigned      WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic [WIDTH-1:0] in,
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    output logic [WIDTH-1:0] out
`ifdef LOADABLE_DFF_VALID_EN
    ,
    output logic             valid
`endif
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_cell #(
            .RST_VAL(RST_VAL[i])
        ) u_cell (
            .d  (in[i]),
            .clk(clk),
            .clr(clr),
            .en (load),
            .q  (out[i])
        );
    end

`ifdef LOADABLE_DFF_VALID_EN
    // Sticky flag: becomes 1 on the first load after a clear.
    dff_cell #(
        .RST_VAL(1'b0)
    ) u_valid (
        .d  (1'b1),
        .clk(clk),
        .clr(clr),
        .en (load),
        .q  (valid)
    );
`endif

endmodule

// File: tb/tb_loadable_dff.sv
// Table-driven, scoreboarded bench for loadable_dff at WIDTH=1 and WIDTH=4.
module tb_loadable_dff;

    logic       clk  = 1'b0;
    logic       clr  = 1'b1;
    logic       load = 1'b0;
    logic       in1  = 1'b0;
    logic [3:0] in4  = 4'h0;
    logic       out1;
    logic [3:0] out4;
`ifdef LOADABLE_DFF_VALID_EN
    logic       valid1;
    logic       valid4;
`endif

    int unsigned n_total  = 0;
    int unsigned n_passed = 0;
    logic        vmodel   = 1'b0;

    always #5 clk = ~clk;

    loadable_dff u_dut1 (
        .in   (in1),
        .clk  (clk),
        .clr  (clr),
        .load (load),
        .out  (out1)
`ifdef LOADABLE_DFF_VALID_EN
        ,
        .valid(valid1)
`endif
    );

    loadable_dff #(
        .WIDTH(4)
    ) u_dut4 (
        .in   (in4),
        .clk  (clk),
        .clr  (clr),
        .load (load),
        .out  (out4)
`ifdef LOADABLE_DFF_VALID_EN
        ,
        .valid(valid4)
`endif
    );

    typedef struct packed {
        logic       clr;
        logic       load;
        logic [3:0] in;
        logic [3:0] exp;
    } vec_t;

    typedef struct packed {
        logic [3:0] out;
        logic       valid;
    } exp_t;

    vec_t vecs [18];
    exp_t sb [$];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            n_passed++;
        end
    endtask

    task automatic check_now(input string tag, input logic [3:0] exp, input logic expv);
        check({tag, "_out1"}, {3'b000, out1}, {3'b000, exp[0]});
        check({tag, "_out4"}, out4, exp);
`ifdef LOADABLE_DFF_VALID_EN
        check({tag, "_valid1"}, {3'b000, valid1}, {3'b000, expv});
        check({tag, "_valid4"}, {3'b000, valid4}, {3'b000, expv});
`else
        if (expv !== expv) n_total++;
`endif
    endtask

    // Drive on the falling edge, push the expectation, compare after the rising edge.
    task automatic step(input logic c, input logic l, input logic [3:0] i, input logic [3:0] e,
                        input string tag);
        exp_t x;
        @(negedge clk);
        clr  = c;
        load = l;
        in1  = i[0];
        in4  = i;
        if (!c)     vmodel = 1'b0;
        else if (l) vmodel = 1'b1;
        sb.push_back('{out: e, valid: vmodel});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check_now(tag, x.out, x.valid);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // clr held with load=1: clear must dominate
        for (int k = 0; k < 5; k++) vecs[k] = '{1'b0, 1'b1, 4'hF, 4'h0};
        vecs[5]  = '{1'b1, 1'b1, 4'h5, 4'h5};
        vecs[6]  = '{1'b1, 1'b1, 4'h2, 4'h2};
        vecs[7]  = '{1'b1, 1'b1, 4'h3, 4'h3};
        vecs[8]  = '{1'b1, 1'b0, 4'hC, 4'h3};
        vecs[9]  = '{1'b1, 1'b0, 4'hD, 4'h3};
        vecs[10] = '{1'b1, 1'b0, 4'hC, 4'h3};
        vecs[11] = '{1'b1, 1'b0, 4'hD, 4'h3};
        vecs[12] = '{1'b1, 1'b0, 4'hC, 4'h3};
        vecs[13] = '{1'b1, 1'b1, 4'hC, 4'hC};
        vecs[14] = '{1'b1, 1'b1, 4'h5, 4'h5};
        vecs[15] = '{1'b1, 1'b1, 4'hA, 4'hA};
        vecs[16] = '{1'b1, 1'b0, 4'h5, 4'hA};
        vecs[17] = '{1'b1, 1'b1, 4'hF, 4'hF};

        // Asynchronous clear without any clock edge
        #2;
        clr  = 1'b0;
        load = 1'b1;
        in1  = 1'b1;
        in4  = 4'hF;
        #1;
        vmodel = 1'b0;
        check_now("reset", 4'h0, 1'b0);

        foreach (vecs[k]) begin
            step(vecs[k].clr, vecs[k].load, vecs[k].in, vecs[k].exp, $sformatf("vec%0d", k));
        end

        // Mid-cycle clear: out drops before the next rising edge
        @(negedge clk);
        clr    = 1'b0;
        vmodel = 1'b0;
        #1;
        check_now("midclr", 4'h0, 1'b0);
        @(posedge clk);
        #1;
        check_now("clr_vs_edge", 4'h0, 1'b0);

        // Clear released with load=0: still zero until a load
        step(1'b1, 1'b0, 4'hF, 4'h0, "release_hold");
        step(1'b1, 1'b0, 4'h9, 4'h0, "release_hold2");
        step(1'b1, 1'b1, 4'h6, 4'h6, "first_load");
        step(1'b1, 1'b1, 4'h9, 4'h9, "second_load");

        // Clear pulse between edges, released before the next edge
        @(negedge clk);
        load   = 1'b0;
        clr    = 1'b0;
        vmodel = 1'b0;
        #1;
        clr = 1'b1;
        #1;
        check_now("pulse_clr", 4'h0, 1'b0);
        step(1'b1, 1'b1, 4'h7, 4'h7, "after_pulse");

        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL scoreboard: got %0d leftover entries, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
